// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage:
// load types, FSM states and byte-enable constants.
package wb_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LB        = 3'd1;
  localparam logic [2:0] LBU       = 3'd2;
  localparam logic [2:0] LH        = 3'd3;
  localparam logic [2:0] LHU       = 3'd4;
  localparam logic [2:0] LW        = 3'd5;
  localparam logic [2:0] LWL       = 3'd6;
  localparam logic [2:0] LWR       = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [3:0] WE_ALL  = 4'b1111;
  localparam logic [3:0] WE_NONE = 4'b0000;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/wb_writeback_if.sv
// Regfile write port: byte enables, address, data.
// master drives the write, slave is the regfile/bypass side.
interface wb_writeback_if;
  import wb_pkg::*;

  logic [3:0]    we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  modport master (output we, output waddr, output wdata);
  modport slave  (input we, input waddr, input wdata);

endinterface

// File: rtl/wb_writeback_load_align.sv
// Load data alignment: extracts/extends the addressed
// bytes and merges unaffected bytes from the old rt.
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] dresp_data,
  input  logic [31:0] rt_old,
  output logic [3:0]  we4,
  output logic [31:0] data32
);

  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] lane;
  logic [7:0]  b;
  logic [15:0] h;

  assign lane = dresp_data >> {addr_lo, 3'b000};
  assign b    = lane[7:0];
  assign h    = addr_lo[1] ? dresp_data[31:16]
                           : dresp_data[15:0];

  always_comb begin
    we4     = WE_ALL;
    shifted = dresp_data;
    unique case (op)
      LB:  shifted = {{24{b[7]}}, b};
      LBU: shifted = {24'd0, b};
      LH:  shifted = {{16{h[15]}}, h};
      LHU: shifted = {16'd0, h};
      LW:  shifted = dresp_data;
      LWL: begin
        we4     = WE_ALL << (2'd3 - addr_lo);
        shifted = dresp_data << {2'd3 - addr_lo, 3'b000};
      end
      LWR: begin
        we4     = WE_ALL >> addr_lo;
        shifted = lane;
      end
      default: we4 = WE_NONE;
    endcase
  end

  assign mask   = byte_mask(we4);
  assign data32 = (shifted & mask) | (rt_old & ~mask);

endmodule

// File: rtl/wb_writeback.sv
// MEM/WB register and load-response wait FSM driving
// the byte-enabled regfile write port.
module wb_writeback
  import wb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [3:0]    mem_wen,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  input  logic [2:0]    mem_load_op,
  input  logic [1:0]    mem_addr_lo,
  input  logic [DW-1:0] mem_rt_old,
  input  logic          stall,
  input  logic          flush,
  input  logic          dresp_valid,
  input  logic [DW-1:0] dresp_data,
  wb_writeback_if.master rf,
  output logic          stallreq,
  output logic          mem_nofwd
);

  logic [1:0]    state;
  logic [AW-1:0] pend_waddr;
  logic [2:0]    pend_op;
  logic [1:0]    pend_lo;
  logic [DW-1:0] pend_rt;
  logic [3:0]    al_we;
  logic [DW-1:0] al_data;
  logic          capture;
  logic          is_load;

  assign stallreq  = (state == ST_WAIT) || (state == ST_DRAIN);
  assign is_load   = mem_load_op != LOAD_NONE;
  assign mem_nofwd = mem_valid && is_load;
  assign capture   = mem_valid && !stall && !stallreq && !flush;

  load_align u_align (
    .op         (pend_op),
    .addr_lo    (pend_lo),
    .dresp_data (dresp_data),
    .rt_old     (pend_rt),
    .we4        (al_we),
    .data32     (al_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rf.we      <= WE_NONE;
      rf.waddr   <= '0;
      rf.wdata   <= '0;
      pend_waddr <= '0;
      pend_op    <= LOAD_NONE;
      pend_lo    <= '0;
      pend_rt    <= '0;
    end else begin
      rf.we <= WE_NONE;
      unique case (state)
        ST_IDLE: begin
          if (capture && is_load) begin
            pend_waddr <= mem_waddr;
            pend_op    <= mem_load_op;
            pend_lo    <= mem_addr_lo;
            pend_rt    <= mem_rt_old;
            state      <= ST_WAIT;
          end else if (capture) begin
            rf.we    <= (mem_waddr == '0) ? WE_NONE : mem_wen;
            rf.waddr <= mem_waddr;
            rf.wdata <= mem_wdata;
          end
        end
        ST_WAIT: begin
          if (dresp_valid) begin
            state <= ST_IDLE;
            // a flushed load still consumes its response
            if (!flush) begin
              rf.we    <= (pend_waddr == '0) ? WE_NONE : al_we;
              rf.waddr <= pend_waddr;
              rf.wdata <= al_data;
            end
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (dresp_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
